kernel_kcore_start_fifo_param: RTL and testbench

Parametrised shift-register FIFO for start/token synchronisation between kcore dataflow processes, for example between the scheduler and the write-back stages. It generalises the fixed start FIFO: width and depth are free parameters, and it adds a registered occupancy count, programmable almost-full/almost-empty flags and optional sticky overflow/underflow detection. Storage is an SRL-style shift chain with a moving read pointer; `if_dout` is first-word-fall-through.

---
 rtl/kernel_kcore_start_fifo_param.sv | 110 +++++++++++
 tb/tb_kernel_kcore_start_fifo_param.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/kernel_kcore_start_fifo_param.sv
// kernel_kcore_start_fifo_param
// Parametrised shift-register start/token FIFO for kcore dataflow processes.
// Storage is a shift chain written at index 0. The read pointer follows the
// oldest entry at count-1, and if_dout is first-word-fall-through.
// Occupancy and all flags are registered from the next count, so there is
// no combinational path from if_read to if_full_n.
// Optional feature: define KCORE_FIFO_ERR_CHECK_EN to enable the sticky
// overflow (if_err[0]) and underflow (if_err[1]) flags. When the macro is
// undefined, if_err is tied to 2'b00.
module kernel_kcore_start_fifo_param #(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 2,
    parameter int DEPTH      = 4,
    parameter int AF_LEVEL   = DEPTH - 1,
    parameter int AE_LEVEL   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_write,
    input  logic                  if_write_ce,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_full_n,
    output logic                  if_almost_full_n,
    input  logic                  if_read,
    input  logic                  if_read_ce,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic                  if_empty_n,
    output logic                  if_almost_empty_n,
    output logic [ADDR_WIDTH:0]   if_count,
    output logic [1:0]            if_err
);

    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(AE_LEVEL);
    localparam logic [ADDR_WIDTH:0] ONE_C   = (ADDR_WIDTH+1)'(1);

    logic [DATA_WIDTH-1:0] srl [DEPTH];
    logic                  wr;
    logic                  rd;
    logic [ADDR_WIDTH:0]   count_m1;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [ADDR_WIDTH:0]   count_next;

    // A request is effective only when qualified and the registered flag allows it.
    assign wr = if_write & if_write_ce & if_full_n;
    assign rd = if_read & if_read_ce & if_empty_n;

    // The oldest entry sits at count-1. The pointer is parked at 0 when the FIFO is empty.
    assign count_m1 = if_count - ONE_C;
    assign rd_addr  = (if_count != '0) ? count_m1[ADDR_WIDTH-1:0] : '0;
    assign if_dout  = srl[rd_addr];

    // Shift the chain on every accepted write. A concurrent read needs no
    // data movement because the count, and therefore the pointer, holds.
    always_ff @(posedge clk) begin
        if (!reset && wr) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                srl[i] <= srl[i-1];
            end
            srl[0] <= if_din;
        end
    end

    // Next occupancy. The full/empty masking on wr/rd keeps it within 0..DEPTH.
    always_comb begin
        count_next = if_count;
        if (wr && !rd) begin
            count_next = if_count + ONE_C;
        end else if (rd && !wr) begin
            count_next = if_count - ONE_C;
        end
    end

    // Register the count and derive every flag from the next count.
    always_ff @(posedge clk) begin
        if (reset) begin
            if_count          <= '0;
            if_empty_n        <= 1'b0;
            if_full_n         <= 1'b1;
            if_almost_full_n  <= 1'b1;
            if_almost_empty_n <= 1'b0;
        end else begin
            if_count          <= count_next;
            if_empty_n        <= (count_next != '0);
            if_full_n         <= (count_next != DEPTH_C);
            if_almost_full_n  <= (count_next < AF_C);
            if_almost_empty_n <= (count_next > AE_C);
        end
    end

`ifdef KCORE_FIFO_ERR_CHECK_EN
    // Sticky error flags: a write attempted while full, or a read attempted while empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            if_err <= 2'b00;
        end else begin
            if (if_write && if_write_ce && !if_full_n) begin
                if_err[0] <= 1'b1;
            end
            if (if_read && if_read_ce && !if_empty_n) begin
                if_err[1] <= 1'b1;
            end
        end
    end
`else
    assign if_err = 2'b00;
`endif

endmodule

// File: tb/tb_kernel_kcore_start_fifo_param.sv
// Directed bench for kernel_kcore_start_fifo_param (DATA_WIDTH=8, DEPTH=4).
module tb_kernel_kcore_start_fifo_param;

    logic       clk = 1'b0;
    logic       reset;
    logic       if_write;
    logic       if_write_ce;
    logic [7:0] if_din;
    logic       if_full_n;
    logic       if_almost_full_n;
    logic       if_read;
    logic       if_read_ce;
    logic [7:0] if_dout;
    logic       if_empty_n;
    logic       if_almost_empty_n;
    logic [2:0] if_count;
    logic [1:0] if_err;

    int tests_run = 0;
    int tests_failed = 0;

`ifdef KCORE_FIFO_ERR_CHECK_EN
    localparam logic [1:0] EXP_OVF = 2'b01;
    localparam logic [1:0] EXP_UNF = 2'b10;
`else
    localparam logic [1:0] EXP_OVF = 2'b00;
    localparam logic [1:0] EXP_UNF = 2'b00;
`endif

    kernel_kcore_start_fifo_param #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(2),
        .DEPTH(4),
        .AF_LEVEL(3),
        .AE_LEVEL(1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .if_write(if_write),
        .if_write_ce(if_write_ce),
        .if_din(if_din),
        .if_full_n(if_full_n),
        .if_almost_full_n(if_almost_full_n),
        .if_read(if_read),
        .if_read_ce(if_read_ce),
        .if_dout(if_dout),
        .if_empty_n(if_empty_n),
        .if_almost_empty_n(if_almost_empty_n),
        .if_count(if_count),
        .if_err(if_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        if_write = 1'b1;
        if_din   = d;
        step();
        if_write = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [7:0] exp);
        check(tag, {24'd0, if_dout}, {24'd0, exp});
        if_read = 1'b1;
        step();
        if_read = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        if_write    = 1'b0;
        if_write_ce = 1'b1;
        if_din      = 8'h00;
        if_read     = 1'b0;
        if_read_ce  = 1'b1;
        do_reset();

        check("rst_count", {29'd0, if_count}, 32'd0);
        check("rst_empty_n", {31'd0, if_empty_n}, 32'd0);
        check("rst_full_n", {31'd0, if_full_n}, 32'd1);
        check("rst_af_n", {31'd0, if_almost_full_n}, 32'd1);
        check("rst_ae_n", {31'd0, if_almost_empty_n}, 32'd0);
        check("rst_err", {30'd0, if_err}, 32'd0);

        // A single write becomes visible right after its edge.
        push(8'h01);
        check("w1_empty_n", {31'd0, if_empty_n}, 32'd1);
        check("w1_count", {29'd0, if_count}, 32'd1);
        check("w1_dout", {24'd0, if_dout}, 32'h01);
        check("w1_ae_n", {31'd0, if_almost_empty_n}, 32'd0);
        pop_check("w1_pop", 8'h01);
        check("w1_drained", {31'd0, if_empty_n}, 32'd0);

        // Fill the FIFO with no reads, then drain it in order.
        push(8'hA0);
        push(8'hA1);
        check("fill2_ae_n", {31'd0, if_almost_empty_n}, 32'd1);
        check("fill2_af_n", {31'd0, if_almost_full_n}, 32'd1);
        push(8'hA2);
        check("fill3_af_n", {31'd0, if_almost_full_n}, 32'd0);
        check("fill3_full_n", {31'd0, if_full_n}, 32'd1);
        push(8'hA3);
        check("fill4_full_n", {31'd0, if_full_n}, 32'd0);
        check("fill4_count", {29'd0, if_count}, 32'd4);
        for (int i = 0; i < 4; i++) begin
            pop_check("drain_A", 8'hA0 + 8'(i));
        end
        check("drainA_empty_n", {31'd0, if_empty_n}, 32'd0);
        check("drainA_count", {29'd0, if_count}, 32'd0);

        // At count 2, read and write together for 10 cycles.
        push(8'hB0);
        push(8'hB1);
        for (int i = 0; i < 10; i++) begin
            check("rw_dout", {24'd0, if_dout}, {24'd0, 8'hB0 + 8'(i)});
            if_write = 1'b1;
            if_read  = 1'b1;
            if_din   = 8'hB2 + 8'(i);
            step();
            check("rw_count", {29'd0, if_count}, 32'd2);
        end
        if_write = 1'b0;
        if_read  = 1'b0;
        pop_check("rw_tail0", 8'hBA);
        pop_check("rw_tail1", 8'hBB);
        check("rw_empty", {31'd0, if_empty_n}, 32'd0);

        // A write while full is rejected and, with error checking enabled, flagged.
        for (int i = 0; i < 4; i++) push(8'hC0 + 8'(i));
        if_write = 1'b1;
        if_din   = 8'hFF;
        step();
        check("ovf_count", {29'd0, if_count}, 32'd4);
        check("ovf_dout", {24'd0, if_dout}, 32'hC0);
        check("ovf_err", {30'd0, if_err}, {30'd0, EXP_OVF});
        if_read = 1'b1;
        step();
        check("fullrw_count", {29'd0, if_count}, 32'd3);
        check("fullrw_full_n", {31'd0, if_full_n}, 32'd1);
        if_read = 1'b0;
        step();
        if_write = 1'b0;
        check("refill_count", {29'd0, if_count}, 32'd4);
        pop_check("ovf_pop0", 8'hC1);
        pop_check("ovf_pop1", 8'hC2);
        pop_check("ovf_pop2", 8'hC3);
        pop_check("ovf_pop3", 8'hFF);
        check("ovf_err_hold", {30'd0, if_err}, {30'd0, EXP_OVF});

        // Reads on an empty FIFO are ignored.
        do_reset();
        check("clr_err", {30'd0, if_err}, 32'd0);
        if_read = 1'b1;
        repeat (3) step();
        if_read = 1'b0;
        check("unf_count", {29'd0, if_count}, 32'd0);
        check("unf_err", {30'd0, if_err}, {30'd0, EXP_UNF});

        // At empty, a simultaneous read and write performs only the write.
        if_read  = 1'b1;
        if_write = 1'b1;
        if_din   = 8'h5A;
        step();
        if_read  = 1'b0;
        if_write = 1'b0;
        check("emptyrw_count", {29'd0, if_count}, 32'd1);
        check("emptyrw_dout", {24'd0, if_dout}, 32'h5A);

        // A reset asserted together with a write discards everything.
        push(8'h11);
        push(8'h22);
        check("pre_rst_count", {29'd0, if_count}, 32'd3);
        reset    = 1'b1;
        if_write = 1'b1;
        if_din   = 8'h33;
        step();
        reset    = 1'b0;
        if_write = 1'b0;
        check("midrst_count", {29'd0, if_count}, 32'd0);
        check("midrst_empty_n", {31'd0, if_empty_n}, 32'd0);
        check("midrst_full_n", {31'd0, if_full_n}, 32'd1);
        check("midrst_ae_n", {31'd0, if_almost_empty_n}, 32'd0);
        check("midrst_err", {30'd0, if_err}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
